// File: rtl/sram_bank.sv
// Parametrised single-port synchronous SRAM bank with byte enables, a registered
// read pipeline of RD_LAT stages, out-of-range detection and a post-reset zeroing sweep.
module sram_bank #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr,
  input  logic [WIDTH/8-1:0] be,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               init_busy,
  output logic               err
);

  localparam int          NBYTES  = WIDTH / 8;
  localparam int unsigned DEPTH_U = DEPTH;

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  if ((WIDTH % 8) != 0 || WIDTH < 8 || RD_LAT < 1 || RD_LAT > 4 || DEPTH < 2) begin : g_bad_params
    $fatal(1, "sram_bank: illegal parameters WIDTH=%0d DEPTH=%0d RD_LAT=%0d", WIDTH, DEPTH, RD_LAT);
  end

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;

  logic              ready;
  logic              in_range;
  logic              ptr_last;
  logic              req_rd;
  logic              req_wr;
  logic [WIDTH-1:0]  word_sel;

  logic [WIDTH-1:0]  data_p [RD_LAT];
  logic              vld_p  [RD_LAT];

  assign ready    = (state_q == S_READY);
  assign in_range = (32'(addr) < DEPTH_U);
  assign ptr_last = (32'(ptr_q) == (DEPTH_U - 32'd1));
  assign req_wr   = ready & en & wr & in_range;
  assign req_rd   = ready & en & ~wr;
  // Out-of-range reads still travel the pipeline, carrying a zero word.
  assign word_sel = in_range ? mem[addr] : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = en & (~ready | ~in_range);
    if (!ready) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_last) begin
        state_d = S_READY;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr_q] <= '0;
    end else if (req_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) vld_p[i] <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
      vld_p[0] <= req_rd;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Read data pipeline: stage 0 captures at the request edge, later stages shift.
  always_ff @(posedge clk) begin
    if (req_rd) data_p[0] <= word_sel;
    for (int i = 1; i < RD_LAT; i++) data_p[i] <= data_p[i-1];
  end

  assign rd_valid  = vld_p[RD_LAT-1];
  assign rd_data   = rd_valid ? data_p[RD_LAT-1] : '0;
  assign init_busy = ~ready;
  assign err       = err_q;

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank (WIDTH=32, DEPTH=24, RD_LAT=2): directed steps
// followed by random traffic, compared cycle by cycle against a scheduled reference model.
module tb_sram_bank;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 24;
  localparam int RD_LAT = 2;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int MAXC   = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              wr = 1'b0;
  logic [3:0]        be = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;
  logic              init_busy;
  logic              err;

  sram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .be(be), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .init_busy(init_busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents plus per-edge expectations of outputs.
  logic [31:0] mem_m [DEPTH];
  bit          exp_v [MAXC];
  logic [31:0] exp_d [MAXC];
  bit          exp_e [MAXC];
  int          edge_n    = 0;
  int          init_left = 0;
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  logic [31:0] last_rd   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    for (int i = edge_n + 1; i < MAXC; i++) begin
      exp_v[i] = 1'b0;
      exp_e[i] = 1'b0;
    end
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
    rst = 1'b0;
    init_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
  endtask

  // One clock: drive at negedge, apply the model at posedge, check at the next negedge.
  task automatic cycle(input logic e, input logic w, input logic [3:0] b,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int ai;
    int due;
    ai = int'(a);
    en = e; wr = w; be = b; addr = a; wr_data = d;
    @(posedge clk);
    edge_n++;
    if (e) begin
      if (init_left > 0 || ai >= DEPTH) exp_e[edge_n] = 1'b1;
      if (init_left == 0) begin
        due = edge_n + RD_LAT - 1;
        if (!w) begin
          if (due < MAXC) begin
            exp_v[due] = 1'b1;
            exp_d[due] = (ai < DEPTH) ? mem_m[ai] : 32'd0;
          end
        end else if (ai < DEPTH) begin
          for (int i = 0; i < 4; i++) if (b[i]) mem_m[ai][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    if (init_left > 0) init_left--;
    @(negedge clk);
    en = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(exp_v[edge_n]));
    check("rd_data", rd_data, exp_v[edge_n] ? exp_d[edge_n] : 32'd0);
    check("err", 32'(err), 32'(exp_e[edge_n]));
    check("init_busy", 32'(init_busy), 32'(init_left > 0));
    if (rd_valid) begin
      valid_cnt++;
      last_rd = rd_data;
    end
    if (err) err_cnt++;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, '0, 32'd0);
  endtask

  task automatic rd(input int a);
    cycle(1'b1, 1'b0, 4'h0, ADDR_W'(a), 32'd0);
  endtask

  task automatic wrw(input int a, input logic [31:0] d, input logic [3:0] b);
    cycle(1'b1, 1'b1, b, ADDR_W'(a), d);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);

    // Reset, then a read request during the sweep, then count the sweep length.
    do_reset();
    n = 0;
    repeat (3) begin idle(); n++; end
    err_cnt = 0;
    valid_cnt = 0;
    rd(4); n++;
    while (init_busy && n < 100) begin idle(); n++; end
    check("init_len", 32'(n), 32'(DEPTH));
    check("init_req_err", 32'(err_cnt), 32'd1);
    check("init_req_novalid", 32'(valid_cnt), 32'd0);

    // Every word reads back as zero after the sweep.
    valid_cnt = 0;
    for (int i = 0; i < DEPTH; i++) rd(i);
    repeat (RD_LAT) idle();
    check("init_reads", 32'(valid_cnt), 32'(DEPTH));

    // Byte enables.
    wrw(5, 32'hAABBCCDD, 4'b1111);
    wrw(5, 32'h11223344, 4'b0101);
    rd(5);
    repeat (RD_LAT) idle();
    check("byte_en", last_rd, 32'hAA22CC44);

    // Write then read next cycle returns new data.
    wrw(9, 32'h0BADF00D, 4'b1111);
    rd(9);
    repeat (RD_LAT) idle();
    check("wr_then_rd", last_rd, 32'h0BADF00D);

    // Pipelined back-to-back reads.
    for (int k = 0; k < 8; k++) wrw(k, 32'(k) * 32'h01010101, 4'b1111);
    valid_cnt = 0;
    for (int k = 0; k < 8; k++) rd(k);
    repeat (RD_LAT) idle();
    check("pipe_reads", 32'(valid_cnt), 32'd8);
    check("pipe_last", last_rd, 32'h07070707);

    // Out-of-range write and read.
    err_cnt = 0;
    valid_cnt = 0;
    wrw(30, 32'hDEADBEEF, 4'b1111);
    rd(30);
    repeat (RD_LAT) idle();
    check("oor_err", 32'(err_cnt), 32'd2);
    check("oor_valid", 32'(valid_cnt), 32'd1);
    check("oor_data", last_rd, 32'd0);
    for (int i = 0; i < DEPTH; i++) rd(i);
    repeat (RD_LAT) idle();

    // Reset half a cycle after a read request: the read must vanish.
    valid_cnt = 0;
    rd(3);
    do_reset();
    n = 0;
    while (init_busy && n < 100) begin idle(); n++; end
    check("reinit_len", 32'(n), 32'(DEPTH));
    check("reset_drop_read", 32'(valid_cnt), 32'd0);
    rd(3);
    repeat (RD_LAT) idle();
    check("reinit_zero", last_rd, 32'd0);

    // Random traffic, including out-of-range addresses and partial byte enables.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            ADDR_W'($urandom_range(0, 31)), $urandom);
    end
    repeat (RD_LAT) idle();
    for (int i = 0; i < DEPTH; i++) rd(i);
    repeat (RD_LAT) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
